// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_arb_pkg;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Grant identifiers; also the encoding of last_grant
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Width needed to hold the value LATENCY without wrapping
   function automatic int tmr_width(input int latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Down-counter timing one memory access; done flags the final access cycle.
// Latency: loads on the edge where load is high; counts down one per cycle after that.
// Backpressure: none; it stops at zero and holds there until the next load.
module mem_lat_timer #(
   parameter int TW = 4
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic [TW-1:0] count,
   output logic          done
);

   // Load on grant, otherwise count down and saturate at zero
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == TW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (I) and load/store (D).
// Latency: grant edge t, BUSY t+1..t+LATENCY, ack pulse at t+LATENCY+1; LATENCY+2 per txn.
// Backpressure: the losing side keeps its stall high and its request stays pending.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY = 8,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,
   output logic            i_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic            d_stall,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy
);

   localparam int TW = tmr_width(LATENCY);

   state_t        state;
   logic          gnt_id;
   logic          last_grant;
   logic          lat_we;
   logic          grant_vld;
   logic          grant_side;
   logic [TW-1:0] tmr_count;
   logic          tmr_done;

   // Arbitration: only in IDLE; on conflict the side that did not win last time goes next
   always_comb begin
      grant_vld  = 1'b0;
      grant_side = GNT_I;
      if (state == IDLE) begin
         if (i_req && d_req) begin
            grant_vld  = 1'b1;
            grant_side = ~last_grant;
         end else if (d_req) begin
            grant_vld  = 1'b1;
            grant_side = GNT_D;
         end else if (i_req) begin
            grant_vld  = 1'b1;
            grant_side = GNT_I;
         end
      end
   end

   mem_lat_timer #(
      .TW (TW)
   ) u_timer (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .load     (grant_vld),
      .load_val (TW'(LATENCY)),
      .count    (tmr_count),
      .done     (tmr_done)
   );

   // Sequencer: IDLE -> BUSY for LATENCY cycles -> one RESP cycle carrying the ack
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state      <= IDLE;
         gnt_id     <= GNT_I;
         last_grant <= GNT_I;
         mem_en     <= 1'b0;
         busy       <= 1'b0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  state      <= BUSY;
                  gnt_id     <= grant_side;
                  last_grant <= grant_side;
                  mem_en     <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            BUSY: begin
               if (tmr_done) begin
                  state  <= RESP;
                  mem_en <= 1'b0;
                  if (gnt_id == GNT_I) begin
                     i_ack <= 1'b1;
                  end else begin
                     d_ack <= 1'b1;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               mem_en <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   // Request latch at grant and read-data capture on the last BUSY cycle
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant_vld) begin
            if (grant_side == GNT_D) begin
               lat_we    <= d_we;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
               mem_be    <= d_we ? d_be : '1;
            end else begin
               lat_we    <= 1'b0;
               mem_addr  <= i_addr;
               mem_wdata <= '0;
               mem_be    <= '1;
            end
         end
         if (state == BUSY && tmr_done) begin
            if (gnt_id == GNT_I) begin
               i_rdata <= mem_rdata;
            end else if (!lat_we) begin
               d_rdata <= mem_rdata;
            end
         end
      end
   end

   // Write strobe only in the first BUSY cycle, when the timer still holds its load value
   assign mem_we  = (state == BUSY) && lat_we && (tmr_count == TW'(LATENCY));

   assign i_stall = i_req && !i_ack;
   assign d_stall = d_req && !d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LATENCY=8 instance plus a LATENCY=1 instance.
// Expected acks (side, data, cycle) are queued at stimulus time and popped on each ack.
// Memory model returns valid data only in the last BUSY cycle, garbage otherwise.
module tb_mem_port_arbiter;

   localparam int L = 8;

   typedef struct {
      bit          side;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;

   logic        i_req = 0, d_req = 0, d_we = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0]  d_be = 0;
   logic        i_ack, d_ack, i_stall, d_stall, mem_en, mem_we, busy;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   logic        i_req1 = 0;
   logic [31:0] i_addr1 = 0;
   logic        i_ack1, d_ack1, i_stall1, d_stall1, mem_en1, mem_we1, busy1;
   logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [3:0]  mem_be1;

   int   cyc = 0;
   int   en_cnt = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   lg = 1'b0;
   logic [31:0] d_rd_model = 32'h0;
   exp_t q[$];
   exp_t q1[$];
   exp_t e, e1;

   always #5 CLK = ~CLK;

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'hDEADBFEF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   mem_port_arbiter #(.LATENCY(L), .AW(32), .DW(32)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (
      .CLK(CLK), .RSTn(RSTn),
      .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1), .i_stall(i_stall1),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
      .d_ack(d_ack1), .d_rdata(d_rdata1), .d_stall(d_stall1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) en_cnt <= 0;
      else       en_cnt <= mem_en ? en_cnt + 1 : 0;
   end

   assign mem_rdata  = (mem_en && en_cnt == L - 1) ? f(mem_addr) : 32'hBAD0BAD0;
   assign mem_rdata1 = mem_en1 ? f(mem_addr1) : 32'hBAD1BAD1;

   always @(negedge CLK) begin
      if (i_ack || d_ack) begin
         chk("ack_onehot", i_ack & d_ack, 0);
         chk("ack_pending", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ack_side", d_ack, e.side);
            chk("ack_cyc", cyc, e.cyc);
            chk("ack_data", d_ack ? d_rdata : i_rdata, e.data);
         end
      end
      if (i_ack1 || d_ack1) begin
         chk("l1_ack_pending", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("l1_ack_side", d_ack1, e1.side);
            chk("l1_ack_cyc", cyc, e1.cyc);
            chk("l1_ack_data", i_rdata1, e1.data);
         end
      end
   end

   task automatic wait_ack(input bit side);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(side ? d_ack : i_ack) && n < 40);
      chk(side ? "d_ack_seen" : "i_ack_seen", side ? d_ack : i_ack, 1);
      if (side) d_req = 1'b0;
      else      i_req = 1'b0;
   endtask

   task automatic run_txn(input bit side, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
      int          c0;
      logic [31:0] dexp;
      @(posedge CLK); #1;
      c0 = cyc;
      if (side) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      dexp = (side && we) ? d_rd_model : f(addr);
      if (side && !we) d_rd_model = dexp;
      q.push_back('{side, dexp, c0 + L + 1});
      lg = side;
      for (int k = 0; k <= L + 2; k++) begin
         @(negedge CLK);
         chk("mem_en", mem_en, (k >= 1 && k <= L));
         chk("busy", busy, (k >= 1 && k <= L + 1));
         chk("mem_we", mem_we, (k == 1 && we));
         chk("stall", side ? d_stall : i_stall, (k <= L));
         if (k >= 1 && k <= L) begin
            chk("mem_addr", mem_addr, addr);
            chk("mem_be", mem_be, (side && we) ? be : 4'hF);
            if (side && we) chk("mem_wdata", mem_wdata, wdata);
         end
         if (k == L + 1) begin
            if (side) d_req = 1'b0;
            else      i_req = 1'b0;
         end
      end
      d_we = 1'b0;
   endtask

   task automatic run_conflict(input logic [31:0] ia, input logic [31:0] da);
      int c0;
      bit w;
      @(posedge CLK); #1;
      c0 = cyc;
      i_req = 1'b1; i_addr = ia;
      d_req = 1'b1; d_we = 1'b0; d_addr = da;
      w = ~lg;
      q.push_back('{w, w ? f(da) : f(ia), c0 + L + 1});
      q.push_back('{~w, w ? f(ia) : f(da), c0 + 2 * L + 3});
      d_rd_model = f(da);
      repeat (5) @(negedge CLK);
      chk("loser_stall", w ? i_stall : d_stall, 1);
      chk("winner_addr", mem_addr, w ? da : ia);
      chk("rd_be_ones", mem_be, 4'hF);
      wait_ack(w);
      wait_ack(~w);
      @(negedge CLK);
   endtask

   task automatic run_drop();
      int c0;
      @(posedge CLK); #1;
      c0 = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      q.push_back('{1'b1, f(32'h400), c0 + L + 1});
      q.push_back('{1'b0, f(32'h600), c0 + 2 * L + 3});
      d_rd_model = f(32'h400);
      @(posedge CLK); #1;
      i_req = 1'b1; i_addr = 32'h600;
      repeat (2) @(posedge CLK);
      #1;
      d_req = 1'b0; d_addr = 32'h999; d_we = 1'b1;
      repeat (2) @(negedge CLK);
      chk("drop_addr", mem_addr, 32'h400);
      chk("drop_we", mem_we, 0);
      chk("drop_en", mem_en, 1);
      wait_ack(1'b1);
      d_we = 1'b0;
      wait_ack(1'b0);
      lg = 1'b0;
      @(negedge CLK);
   endtask

   task automatic run_reset();
      int r;
      @(posedge CLK); #1;
      i_req = 1'b1; i_addr = 32'h500;
      repeat (4) @(posedge CLK);
      #2;
      RSTn = 1'b0;
      #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_i_ack", i_ack, 0);
      chk("rst_i_stall", i_stall, 1);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      lg = 1'b0;
      d_rd_model = 32'h0;
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      r = cyc;
      q.push_back('{1'b0, f(32'h500), r + L + 1});
      wait_ack(1'b0);
      @(negedge CLK);
   endtask

   task automatic run_l1();
      int c0;
      int t;
      @(posedge CLK); #1;
      c0 = cyc;
      i_req1 = 1'b1; i_addr1 = 32'h1000;
      for (int n = 0; n < 4; n++)
         q1.push_back('{1'b0, f(32'h1000 + 32'(16 * n)), c0 + 2 + 3 * n});
      for (int n = 0; n < 4; n++) begin
         t = 0;
         do begin
            @(negedge CLK);
            t++;
         end while (!i_ack1 && t < 20);
         chk("l1_ack_seen", i_ack1, 1);
         i_addr1 = 32'h1000 + 32'(16 * (n + 1));
      end
      i_req1 = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge CLK);
      chk("reset_mem_en", mem_en, 0);
      chk("reset_busy", busy, 0);
      chk("reset_mem_we", mem_we, 0);
      chk("reset_acks", {i_ack, d_ack}, 0);
      chk("reset_mem_be", mem_be, 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_rdata", {i_rdata, d_rdata}, 0);
      chk("reset_stalls", {i_stall, d_stall}, 0);
      RSTn = 1'b1;
      @(negedge CLK);

      run_conflict(32'h100, 32'h300);
      run_conflict(32'h104, 32'h304);
      run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
      run_txn(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
      chk("store_keeps_d_rdata", d_rdata, d_rd_model);
      run_txn(1'b1, 1'b0, 32'h240, 32'hFFFF0000, 4'b1100);
      run_conflict(32'h108, 32'h308);
      run_drop();
      run_reset();
      run_l1();

      repeat (3) @(negedge CLK);
      chk("sb_empty", q.size(), 0);
      chk("l1_sb_empty", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
